washer_fsm: RTL and testbench
=============================

Name: washer_fsm

Overview:
- Top-level cycle sequencer for the washing machine.
- Accepts a coin, then walks IDLE → FillingWater → Washing → Rinsing → Spinning → IDLE.
- Each step advances on the matching one-hot DoneFlags pulse from the timer controller; current_state is driven back to that controller.
- Supports an optional double-wash pass, a spin-only pause request, and a completion indication.

Parameters:
DOUBLE_PASSES, 2, number of Washing+Rinsing passes when double wash is selected (legal range 2..3; single wash is always 1 pass)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous active-low reset
coin_in  input  1  coin inserted; level, sampled each cycle
double_wash  input  1  double-wash request; sampled only when a coin is accepted
timer_pause  input  1  user pause request (honoured only in Spinning)
DoneFlags  input  4  one-hot step completion from the timer controller: 1000 fill, 0100 wash, 0010 rinse, 0001 spin
current_state  output  3  registered state: 000 IDLE, 001 FillingWater, 010 Washing, 011 Rinsing, 100 Spinning
TimerPause  output  1  combinational: timer_pause AND current_state==Spinning
wash_done  output  1  registered; cycle-complete indication
busy  output  1  combinational: current_state != IDLE
pass_count  output  2  registered; number of completed Washing+Rinsing passes in the current cycle

Behaviour:
- Reset (asynchronous, active-low): current_state=IDLE, wash_done=0, pass_count=0, double-wash latch=0.
  - TimerPause=0 and busy=0 follow combinationally from the reset state.
  - Reset asserted mid-cycle aborts immediately to these values.
  - No resume after reset; a new coin is required.
- IDLE: coin_in=1 → FillingWater on the next edge. On the same edge:
  - latch double_wash;
  - clear pass_count to 0;
  - clear wash_done to 0.
  - coin_in is ignored in every other state; it has no effect and is not queued.
- FillingWater: DoneFlags==1000 → Washing.
- Washing: DoneFlags==0100 → Rinsing.
- Rinsing: DoneFlags==0010 → pass_count increments on the same edge.
  - Target = DOUBLE_PASSES if the double-wash latch is set, else 1.
  - If the incremented pass_count is below target → Washing (no refill).
  - Otherwise → Spinning.
- Spinning: DoneFlags==0001 → IDLE and wash_done set to 1 on the same edge.
  - wash_done stays high until the next accepted coin or reset.
- Transition latency is exactly one CLK edge after the flag is seen; DoneFlags is a single-cycle pulse.
- Flag matching:
  - A flag not matching the current state is ignored; state is unchanged.
  - A non-one-hot DoneFlags value is ignored.
  - DoneFlags in IDLE is ignored.
- Pause:
  - TimerPause is asserted only while in Spinning. The FSM does not freeze itself; the timer controller stops the timer, so no Done_Spinning arrives.
  - If Done_Spinning arrives while timer_pause=1, it is still honoured.
  - timer_pause in any other state has no effect and TimerPause stays 0.
- Illegal current_state encodings (101/110/111) → IDLE on the next edge, with pass_count cleared.
- pass_count saturates at 3. It is held after Spinning so software can read it in IDLE.
- Simultaneous coin_in with a DoneFlags pulse in IDLE: coin wins, flag ignored.

Decomposition:
- Shared package (common with the timer controller):
  - state encodings (IDLE..Spinning);
  - the Done_* one-hot constants;
  - timer mode constants RUN/PAUSE/STOP.
- The timer controller's local copies move to this package.
- No sub-module. Next-state logic and registers live in one module; pass counting is a small counter inside the same module.

Test Plan:
- Reset then coin_in=1, double_wash=0 for 1 cycle → current_state 001 next edge, busy=1, wash_done=0. Pulse 1000, 0100, 0010, 0001 in turn → states 010, 011, 100, 000; pass_count=1, wash_done=1.
- Coin with double_wash=1 (DOUBLE_PASSES=2) → after the first 0010 state returns to 010 with pass_count=1. The second 0010 → 100 with pass_count=2. 0001 → IDLE, wash_done=1.
- In Washing, pulse 1000 and 0001 → state stays 010. Pulse 0101 → stays 010. coin_in=1 mid-cycle → no change.
- In Spinning, timer_pause=1 → TimerPause=1 and state stays 100. timer_pause=1 in Rinsing → TimerPause=0.
- Assert RST low mid-Rinsing (asynchronous, between edges) → current_state=000 immediately, pass_count=0, wash_done=0. Release, no coin → stays IDLE.
- wash_done=1 in IDLE, coin_in=1 coincident with DoneFlags=0001 → state 001, wash_done=0, pass_count=0.

Source files
------------

// File: rtl/washer_fsm_pkg.sv
// Encodings shared by the washer cycle sequencer and the timer controller.
// Holds the state codes, the one-hot step-done flags and the timer modes.
package washer_fsm_pkg;

    localparam int STATE_W = 3;
    localparam int FLAG_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'b000,
        ST_FILL  = 3'b001,
        ST_WASH  = 3'b010,
        ST_RINSE = 3'b011,
        ST_SPIN  = 3'b100
    } state_e;

    localparam logic [FLAG_W-1:0] DONE_FILL  = 4'b1000;
    localparam logic [FLAG_W-1:0] DONE_WASH  = 4'b0100;
    localparam logic [FLAG_W-1:0] DONE_RINSE = 4'b0010;
    localparam logic [FLAG_W-1:0] DONE_SPIN  = 4'b0001;

    typedef enum logic [1:0] {
        TMR_RUN   = 2'd0,
        TMR_PAUSE = 2'd1,
        TMR_STOP  = 2'd2
    } timer_mode_e;

endpackage

// File: rtl/washer_fsm_if.sv
// Control/status bundle between the washer sequencer and its surroundings.
// The slave side is the sequencer; the master side drives coin, options and flags.
interface washer_fsm_if;
    import washer_fsm_pkg::*;

    logic                coin_in;
    logic                double_wash;
    logic                timer_pause;
    logic [FLAG_W-1:0]   DoneFlags;
    logic [STATE_W-1:0]  current_state;
    logic                TimerPause;
    logic                wash_done;
    logic                busy;
    logic [1:0]          pass_count;

    modport master (
        output coin_in, double_wash, timer_pause, DoneFlags,
        input  current_state, TimerPause, wash_done, busy, pass_count
    );

    modport slave (
        input  coin_in, double_wash, timer_pause, DoneFlags,
        output current_state, TimerPause, wash_done, busy, pass_count
    );

endinterface

// File: rtl/washer_fsm.sv
// Washing-machine cycle sequencer: coin -> fill -> wash/rinse passes -> spin -> idle,
// each step advanced by the matching one-hot done pulse from the timer controller.
module washer_fsm
    import washer_fsm_pkg::*;
#(
    parameter int DOUBLE_PASSES = 2
)
(
    input  logic       CLK,
    input  logic       RST,
    washer_fsm_if.slave bus
);

    localparam logic [1:0] LP_DOUBLE = 2'(DOUBLE_PASSES);

    state_e      r_state;
    state_e      w_nextState;
    logic        r_doubleLatch;
    logic [1:0]  r_passCount;
    logic        r_washDone;

    logic [1:0]  w_passInc;
    logic [1:0]  w_target;
    logic        w_coinAccept;
    logic        w_rinseDone;
    logic        w_spinDone;
    logic        w_illegal;

    assign w_passInc    = (r_passCount == 2'd3) ? 2'd3 : r_passCount + 2'd1;
    assign w_target     = r_doubleLatch ? LP_DOUBLE : 2'd1;
    assign w_coinAccept = (r_state == ST_IDLE)  && bus.coin_in;
    assign w_rinseDone  = (r_state == ST_RINSE) && (bus.DoneFlags == DONE_RINSE);
    assign w_spinDone   = (r_state == ST_SPIN)  && (bus.DoneFlags == DONE_SPIN);
    assign w_illegal    = !(r_state inside {ST_IDLE, ST_FILL, ST_WASH, ST_RINSE, ST_SPIN});

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Exact-match compares reject both wrong-step and non-one-hot flags.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (bus.coin_in)                   w_nextState = ST_FILL;
            ST_FILL:  if (bus.DoneFlags == DONE_FILL)    w_nextState = ST_WASH;
            ST_WASH:  if (bus.DoneFlags == DONE_WASH)    w_nextState = ST_RINSE;
            ST_RINSE: if (w_rinseDone)
                          w_nextState = (w_passInc < w_target) ? ST_WASH : ST_SPIN;
            ST_SPIN:  if (w_spinDone)                    w_nextState = ST_IDLE;
            default:                                     w_nextState = ST_IDLE;
        endcase
    end

    // pass_count is kept after the cycle ends so it can still be read in IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_doubleLatch <= 1'b0;
            r_passCount   <= 2'd0;
            r_washDone    <= 1'b0;
        end else if (w_illegal) begin
            r_passCount   <= 2'd0;
        end else if (w_coinAccept) begin
            r_doubleLatch <= bus.double_wash;
            r_passCount   <= 2'd0;
            r_washDone    <= 1'b0;
        end else begin
            if (w_rinseDone) begin
                r_passCount <= w_passInc;
            end
            if (w_spinDone) begin
                r_washDone  <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.current_state = r_state;
        bus.busy          = (r_state != ST_IDLE);
        bus.TimerPause    = bus.timer_pause && (r_state == ST_SPIN);
        bus.wash_done     = r_washDone;
        bus.pass_count    = r_passCount;
    end

endmodule

// File: tb/tb_washer_fsm.sv
// Bench for washer_fsm: directed vector table, an asynchronous-reset sequence,
// then random stimulus scored against a step-queue model of the wash cycle.
module tb_washer_fsm;
    import washer_fsm_pkg::*;

    localparam int DP = 2;

    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;

    washer_fsm_if bus ();

    washer_fsm #(.DOUBLE_PASSES(DP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       coin;
        logic       dbl;
        logic       pause;
        logic [3:0] flags;
        logic [2:0] st;
        logic [1:0] pc;
        logic       done;
        logic       busy;
        logic       tp;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [0:NVEC-1];

    // The model sees a cycle as the list of done flags it still has to collect.
    logic [3:0] mQueue[$];
    int         mPass;
    logic       mDone;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int st, input int pc,
                            input int done, input int busy, input int tp);
        checkOutput({tag, ".state"}, int'(bus.current_state), st);
        checkOutput({tag, ".pass"},  int'(bus.pass_count),    pc);
        checkOutput({tag, ".done"},  int'(bus.wash_done),     done);
        checkOutput({tag, ".busy"},  int'(bus.busy),          busy);
        checkOutput({tag, ".tpause"}, int'(bus.TimerPause),   tp);
    endtask

    task automatic applyStimulus(input logic coin, input logic dbl,
                                 input logic pause, input logic [3:0] flags);
        @(negedge CLK);
        bus.coin_in     = coin;
        bus.double_wash = dbl;
        bus.timer_pause = pause;
        bus.DoneFlags   = flags;
    endtask

    task automatic modelReset();
        mQueue.delete();
        mPass = 0;
        mDone = 1'b0;
    endtask

    task automatic modelStep(input logic coin, input logic dbl, input logic [3:0] flags);
        if (mQueue.size() == 0) begin
            if (coin) begin
                mQueue.push_back(DONE_FILL);
                for (int p = 0; p < (dbl ? DP : 1); p++) begin
                    mQueue.push_back(DONE_WASH);
                    mQueue.push_back(DONE_RINSE);
                end
                mQueue.push_back(DONE_SPIN);
                mPass = 0;
                mDone = 1'b0;
            end
        end else if (flags == mQueue[0]) begin
            if (flags == DONE_RINSE) mPass = (mPass < 3) ? mPass + 1 : 3;
            void'(mQueue.pop_front());
            if (mQueue.size() == 0) mDone = 1'b1;
        end
    endtask

    function automatic int modelState();
        if (mQueue.size() == 0) return 0;
        case (mQueue[0])
            DONE_FILL:  return 1;
            DONE_WASH:  return 2;
            DONE_RINSE: return 3;
            default:    return 4;
        endcase
    endfunction

    initial begin
        logic [3:0] rFlags;
        logic       rCoin;
        logic       rDbl;
        logic       rPause;
        int         sel;
        int         st;

        vectors     = 0;
        miscompares = 0;
        RST             = 1'b0;
        bus.coin_in     = 1'b0;
        bus.double_wash = 1'b0;
        bus.timer_pause = 1'b0;
        bus.DoneFlags   = 4'b0000;

        //            coin  dbl   pause flags    st      pc     done  busy  tp
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'b1000, 3'd2, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 3'd3, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b0010, 3'd4, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 3'd4, 2'd1, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'b0001, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b1000, 3'd2, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0100, 3'd3, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0010, 3'd2, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b1000, 3'd2, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0001, 3'd2, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b0101, 3'd2, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 4'b0000, 3'd2, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b0100, 3'd3, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 4'b0000, 3'd3, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'b0010, 3'd4, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 4'b0001, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 4'b1000, 3'd0, 2'd2, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge CLK);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].coin, vecs[i].dbl, vecs[i].pause, vecs[i].flags);
            @(posedge CLK);
            #1;
            checkAll($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].pc),
                     int'(vecs[i].done), int'(vecs[i].busy), int'(vecs[i].tp));
        end

        // Double-wash cycle into its second Rinsing, then reset between edges.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, DONE_FILL);
        applyStimulus(1'b0, 1'b0, 1'b0, DONE_WASH);
        applyStimulus(1'b0, 1'b0, 1'b0, DONE_RINSE);
        applyStimulus(1'b0, 1'b0, 1'b1, DONE_WASH);
        @(posedge CLK);
        #1;
        checkAll("preRst", 3, 1, 0, 1, 0);
        @(negedge CLK);
        bus.DoneFlags = 4'b0000;
        #2;
        RST = 1'b0;
        #1;
        checkAll("asyncRst", 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, DONE_FILL);
        applyStimulus(1'b0, 1'b0, 1'b1, DONE_SPIN);
        @(posedge CLK);
        #1;
        checkAll("postRst", 0, 0, 0, 0, 0);

        modelReset();
        for (int c = 0; c < 1500; c++) begin
            rCoin  = ($urandom_range(0, 9) == 0);
            rDbl   = 1'($urandom_range(0, 1));
            rPause = ($urandom_range(0, 3) == 0);
            sel    = $urandom_range(0, 7);
            if (sel < 4)       rFlags = 4'b0001 << sel;
            else if (sel == 4) rFlags = 4'($urandom_range(0, 15));
            else               rFlags = 4'b0000;
            applyStimulus(rCoin, rDbl, rPause, rFlags);
            modelStep(rCoin, rDbl, rFlags);
            st = modelState();
            @(posedge CLK);
            #1;
            checkAll($sformatf("rnd%0d", c), st, mPass, int'(mDone),
                     (st != 0) ? 1 : 0, (rPause && st == 4) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
